// File: rtl/io_bus_if.sv
// Core data bus plus memory-side signals seen by the io_bus address decoder.
// Handshake: none; reads are combinational, a write commits on the rising clk edge while we=1.
interface io_bus_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ram_we;
  logic [31:0] ram_rd;

  // master = core + memory side, slave = the decoder
  modport master (output we, a, wd, ram_rd, input rd, ram_we);
  modport slave  (input we, a, wd, ram_rd, output rd, ram_we);
endinterface

// File: rtl/io_bus.sv
// Address decoder with LED register, free-running cycle counter and compare timer.
// Optional macro IO_IRQ_EN adds TCTRL.IE and an irq output (EXP & IE).
module io_bus #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int          LED_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  io_bus_if.slave          bus,
  output logic [LED_W-1:0] leds
`ifdef IO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [13:0] OFF_LED   = 14'h0;
  localparam logic [13:0] OFF_CYCLE = 14'h1;
  localparam logic [13:0] OFF_TCMP  = 14'h2;
  localparam logic [13:0] OFF_TCTRL = 14'h3;
  localparam logic [13:0] OFF_TCNT  = 14'h4;

  logic [LED_W-1:0] r_leds;
  logic [31:0]      r_cycle;
  logic [31:0]      r_tcmp;
  logic [31:0]      r_tcnt;
  logic             r_en;
  logic             r_exp;
  logic             r_ie;

  logic             w_io_sel;
  logic             w_wr;
  logic [13:0]      w_off;
  logic             w_wr_led;
  logic             w_wr_tcmp;
  logic             w_wr_ctrl;
  logic             w_clr;
  logic             w_expire;
  logic [31:0]      w_led_rd;
  logic [31:0]      w_ctrl_rd;
  logic [31:0]      w_io_rdata;
  logic             w_unused_ok;

  // Address decode; byte-lane bits a[1:0] play no part in register selection.
  assign w_io_sel    = (bus.a[31:16] == IO_BASE[31:16]);
  assign w_off       = bus.a[15:2];
  assign w_wr        = bus.we & w_io_sel;
  assign w_wr_led    = w_wr & (w_off == OFF_LED);
  assign w_wr_tcmp   = w_wr & (w_off == OFF_TCMP);
  assign w_wr_ctrl   = w_wr & (w_off == OFF_TCTRL);
  assign w_clr       = w_wr_ctrl & bus.wd[2];
  assign w_unused_ok = &{1'b0, bus.a[1:0]};

  // CLR outranks expiry; the match uses the TCMP/EN values held before the edge.
  assign w_expire    = ~w_clr & r_en & (r_tcnt == r_tcmp);

  assign bus.ram_we  = bus.we & ~w_io_sel;
  assign bus.rd      = w_io_sel ? w_io_rdata : bus.ram_rd;
  assign leds        = r_leds;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
      r_tcmp <= 32'hFFFF_FFFF;
    end else begin
      if (w_wr_led)  r_leds <= bus.wd[LED_W-1:0];
      if (w_wr_tcmp) r_tcmp <= bus.wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
      r_en   <= 1'b0;
      r_exp  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_tcnt <= '0;
      end else if (w_expire) begin
        r_tcnt <= '0;
      end else if (r_en) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
      // A same-cycle expiry beats the write-one-to-clear of EXP.
      if (w_expire) begin
        r_exp <= 1'b1;
      end else if (w_wr_ctrl && bus.wd[1]) begin
        r_exp <= 1'b0;
      end
      if (w_wr_ctrl) r_en <= bus.wd[0];
    end
  end

`ifdef IO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_ie <= bus.wd[3];
    end
  end

  assign irq = r_exp & r_ie;
`else
  assign r_ie = 1'b0;
`endif

  always_comb begin
    w_led_rd             = '0;
    w_led_rd[LED_W-1:0]  = r_leds;
    w_ctrl_rd            = '0;
    w_ctrl_rd[0]         = r_en;
    w_ctrl_rd[1]         = r_exp;
    w_ctrl_rd[3]         = r_ie;
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      OFF_LED:   w_io_rdata = w_led_rd;
      OFF_CYCLE: w_io_rdata = r_cycle;
      OFF_TCMP:  w_io_rdata = r_tcmp;
      OFF_TCTRL: w_io_rdata = w_ctrl_rd;
      OFF_TCNT:  w_io_rdata = r_tcnt;
      default:   w_io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus.sv
// Self-checking bench for io_bus: directed scenarios plus random traffic against a behavioural model.
module tb_io_bus;

  logic clk;
  logic reset;
  logic [7:0] leds;
`ifdef IO_IRQ_EN
  logic irq;
`endif

  io_bus_if u_if ();

  io_bus #(.IO_BASE(32'hFFFF_0000), .LED_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave),
    .leds  (leds)
`ifdef IO_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  m_leds;
  logic [31:0] m_cycle;
  logic [31:0] m_tcmp;
  logic [31:0] m_tcnt;
  logic        m_en;
  logic        m_exp;
  logic        m_ie;

  logic [31:0] last_rd;
  logic [31:0] last_ram_rd;
  logic        last_ram_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic is_io(input logic [31:0] addr);
    return addr[31:16] == 16'hFFFF;
  endfunction

  function automatic logic [15:0] offset(input logic [31:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_leds  = 8'h00;
    m_cycle = 32'h0;
    m_tcmp  = 32'hFFFF_FFFF;
    m_tcnt  = 32'h0;
    m_en    = 1'b0;
    m_exp   = 1'b0;
    m_ie    = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr, input logic [31:0] ram_val);
    if (!is_io(addr)) return ram_val;
    case (offset(addr))
      16'h0000: return {24'h0, m_leds};
      16'h0004: return m_cycle;
      16'h0008: return m_tcmp;
      16'h000C: return {28'h0, m_ie, 1'b0, m_exp, m_en};
      16'h0010: return m_tcnt;
      default:  return 32'h0;
    endcase
  endfunction

  // One clock of the register map's rules, applied at the rising edge.
  task automatic model_step(input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic wr_ctrl;
    logic clr;
    logic expire;
    wr_ctrl = w && is_io(addr) && offset(addr) == 16'h000C;
    clr     = wr_ctrl && data[2];
    expire  = 1'b0;
    if (clr) m_tcnt = 0;
    else if (m_en && m_tcnt == m_tcmp) begin
      m_tcnt = 0;
      expire = 1'b1;
    end else if (m_en) m_tcnt = m_tcnt + 1;
    if (expire) m_exp = 1'b1;
    else if (wr_ctrl && data[1]) m_exp = 1'b0;
    if (wr_ctrl) begin
      m_en = data[0];
`ifdef IO_IRQ_EN
      m_ie = data[3];
`endif
    end
    if (w && is_io(addr) && offset(addr) == 16'h0008) m_tcmp = data;
    if (w && is_io(addr) && offset(addr) == 16'h0000) m_leds = data[7:0];
    m_cycle = m_cycle + 1;
  endtask

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic do_cycle(input logic w, input logic [31:0] addr, input logic [31:0] data);
    u_if.we     = w;
    u_if.a      = addr;
    u_if.wd     = data;
    u_if.ram_rd = $urandom();
    #1;
    check("rd", u_if.rd, model_rd(addr, u_if.ram_rd));
    check("ram_we", {31'h0, u_if.ram_we}, {31'h0, w & ~is_io(addr)});
    check("leds", {24'h0, leds}, {24'h0, m_leds});
`ifdef IO_IRQ_EN
    check("irq", {31'h0, irq}, {31'h0, m_exp & m_ie});
`endif
    last_rd     = u_if.rd;
    last_ram_rd = u_if.ram_rd;
    last_ram_we = u_if.ram_we;
    @(posedge clk);
    model_step(w, addr, data);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    do_cycle(1'b1, addr, data);
  endtask

  task automatic rd_chk(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    do_cycle(1'b0, addr, 32'h0);
    check(tag, last_rd, exp);
  endtask

  task automatic wait_tcnt(input logic [31:0] target);
    int n;
    n = 0;
    while (m_tcnt != target && n < 200) begin
      do_cycle(1'b0, 32'hFFFF_0010, 32'h0);
      n++;
    end
    if (m_tcnt != target) check("wait_tcnt_timeout", 32'h0, 32'h1);
  endtask

  // Asynchronous reset mid-run: CYCLE must read 0 before any clock edge.
  task automatic pulse_reset();
    u_if.we = 1'b0;
    u_if.a  = 32'hFFFF_0004;
    #1;
    check("cycle_before_reset_nz", {31'h0, u_if.rd != 0}, 32'h1);
    reset = 1'b1;
    model_reset();
    #1;
    check("cycle_async_reset", u_if.rd, 32'h0);
    @(posedge clk);
    #1;
    check("cycle_held_in_reset", u_if.rd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] lst [0:6];
    int sel;

    lst[0] = 32'hFFFF_0000; lst[1] = 32'hFFFF_0004; lst[2] = 32'hFFFF_0008;
    lst[3] = 32'hFFFF_000C; lst[4] = 32'hFFFF_0010; lst[5] = 32'hFFFF_0020;
    lst[6] = 32'hFFFF_0100;

    reset = 1'b1;
    u_if.we = 1'b0; u_if.a = 32'h0; u_if.wd = 32'h0; u_if.ram_rd = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    rd_chk(32'hFFFF_0000, "led_reset", 32'h0);
    rd_chk(32'hFFFF_0004, "cycle_counting", 32'h1);
    rd_chk(32'hFFFF_0008, "tcmp_reset", 32'hFFFF_FFFF);
    rd_chk(32'hFFFF_000C, "tctrl_reset", 32'h0);
    rd_chk(32'hFFFF_0010, "tcnt_reset", 32'h0);

    // LED and RAM steering
    wr(32'hFFFF_0000, 32'h0000_00A5);
    check("led_write_no_ram_we", {31'h0, last_ram_we}, 32'h0);
    wr(32'h0000_0040, 32'h0000_1234);
    check("ram_write_we", {31'h0, last_ram_we}, 32'h1);
    check("leds_after_ram_write", {24'h0, leds}, 32'hA5);
    do_cycle(1'b0, 32'h0000_0040, 32'h0);
    check("ram_read_passthru", last_rd, last_ram_rd);

    // Timer: TCMP=3, enable, expect 0,1,2,3,0
    wr(32'hFFFF_0008, 32'd3);
    wr(32'hFFFF_000C, 32'h1);
    rd_chk(32'hFFFF_0010, "tcnt_seq0", 32'd0);
    rd_chk(32'hFFFF_0010, "tcnt_seq1", 32'd1);
    rd_chk(32'hFFFF_0010, "tcnt_seq2", 32'd2);
    rd_chk(32'hFFFF_0010, "tcnt_seq3", 32'd3);
    rd_chk(32'hFFFF_0010, "tcnt_seq_wrap", 32'd0);
    rd_chk(32'hFFFF_000C, "exp_set", 32'h3);
    wait_tcnt(32'd1);
    wr(32'hFFFF_000C, 32'h3);
    rd_chk(32'hFFFF_000C, "exp_cleared", 32'h1);
    wait_tcnt(32'd3);
    wr(32'hFFFF_000C, 32'h3);
    rd_chk(32'hFFFF_000C, "exp_set_wins", 32'h3);

    // CLR while running, then disable and hold
    wr(32'hFFFF_0008, 32'd100);
    wait_tcnt(32'd5);
    wr(32'hFFFF_000C, 32'h5);
    rd_chk(32'hFFFF_0010, "tcnt_cleared", 32'd0);
    rd_chk(32'hFFFF_0010, "tcnt_after_clr", 32'd1);
    wr(32'hFFFF_000C, 32'h0);
    rd_chk(32'hFFFF_0010, "tcnt_hold_a", 32'd3);
    rd_chk(32'hFFFF_0010, "tcnt_hold_b", 32'd3);

    // Unmapped and read-only writes
    wr(32'hFFFF_0020, 32'h0000_DEAD);
    wr(32'hFFFF_0004, 32'h0000_DEAD);
    wr(32'hFFFF_0010, 32'h0000_DEAD);
    rd_chk(32'hFFFF_0020, "unmapped_read", 32'h0);
    rd_chk(32'hFFFF_0000, "led_untouched", 32'hA5);
    rd_chk(32'hFFFF_0010, "tcnt_untouched", 32'd3);

    // CYCLE wrap via backdoor
    u_if.we = 1'b0;
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    @(posedge clk);
    m_cycle = 32'hFFFF_FFFF;
    model_step(1'b0, u_if.a, u_if.wd);
    @(negedge clk);
    rd_chk(32'hFFFF_0004, "cycle_wrap", 32'h0);

`ifdef IO_IRQ_EN
    wr(32'hFFFF_0008, 32'd1);
    wr(32'hFFFF_000C, 32'h9);
    begin
      int n;
      n = 0;
      while (last_rd[1] !== 1'b1 && n < 20) begin
        do_cycle(1'b0, 32'hFFFF_000C, 32'h0);
        n++;
      end
      if (last_rd[1] !== 1'b1) check("irq_wait_timeout", 32'h0, 32'h1);
    end
    check("irq_after_expiry", {31'h0, irq}, 32'h1);
    wait_tcnt(32'd0);
    wr(32'hFFFF_000C, 32'hB);
    #1;
    check("irq_cleared", {31'h0, irq}, 32'h0);
`else
    wr(32'hFFFF_000C, 32'h8);
    do_cycle(1'b0, 32'hFFFF_000C, 32'h0);
    check("ie_absent", {31'h0, last_rd[3]}, 32'h0);
`endif

    pulse_reset();
    rd_chk(32'hFFFF_0008, "tcmp_after_reset", 32'hFFFF_FFFF);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6) begin
        addr = lst[sel] | {30'h0, 2'($urandom_range(0, 3))};
      end else begin
        addr = $urandom() & 32'h7FFF_FFFF;
      end
      if (is_io(addr) && offset(addr) == 16'h0008) data = $urandom_range(0, 6);
      else if (is_io(addr) && offset(addr) == 16'h000C) data = $urandom_range(0, 15);
      else data = $urandom();
      do_cycle(1'($urandom_range(0, 1)), addr, data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
